// File: rtl/ula_sequencer.sv
// ula_sequencer: feeds an external ALU from a byte stream.
// Each transaction takes three accepted beats: operand A, operand B, then an opcode.
// The sequencer spends one cycle in EXEC, captures the ALU result and overflow flag,
// and holds them in DONE until the consumer takes them.
// When the opcode's chain bit is set, the captured result becomes operand A of the
// next transaction, so only B and the opcode are loaded again.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   in_data/in_valid/in_ready   beat input (A, B, opcode) with handshake
//   ula_a/ula_b/ula_f       registered ALU operands and function select
//   ula_saida/ula_flag      ALU result and signed-overflow flag (from the external ALU)
//   result/result_ovf       captured ALU result and overflow flag
//   out_valid/out_ready     result handshake
//   ovf_count               saturating count of captured overflows
module ula_sequencer #(
    parameter int unsigned OVF_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [7:0]           ula_a,
    output logic [7:0]           ula_b,
    output logic [1:0]           ula_f,
    input  logic [7:0]           ula_saida,
    input  logic                 ula_flag,
    output logic [7:0]           result,
    output logic                 result_ovf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        LOAD_F,
        EXEC,
        DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [7:0]            r_ula_a;
    logic [7:0]            r_ula_b;
    logic [1:0]            r_ula_f;
    logic                  r_chain;
    logic [7:0]            r_result;
    logic                  r_result_ovf;
    logic [OVF_CNT_W-1:0]  r_ovf_count;
    logic                  w_accept;
    logic                  w_ovf_sat;

    assign w_accept  = in_valid && in_ready;
    assign w_ovf_sat = (r_ovf_count == {OVF_CNT_W{1'b1}});

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= LOAD_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        unique case (r_state)
            LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = LOAD_B;
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = LOAD_F;
            end
            LOAD_F: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = EXEC;
            end
            EXEC: begin
                w_state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = r_chain ? LOAD_B : LOAD_A;
            end
            default: begin
                w_state_next = LOAD_A;
            end
        endcase
    end

    // Operand, result and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ula_a      <= 8'h00;
            r_ula_b      <= 8'h00;
            r_ula_f      <= 2'b00;
            r_chain      <= 1'b0;
            r_result     <= 8'h00;
            r_result_ovf <= 1'b0;
            r_ovf_count  <= '0;
        end else begin
            case (r_state)
                LOAD_A: begin
                    if (w_accept) r_ula_a <= in_data;
                end
                LOAD_B: begin
                    if (w_accept) r_ula_b <= in_data;
                end
                LOAD_F: begin
                    if (w_accept) begin
                        r_ula_f <= in_data[1:0];
                        r_chain <= in_data[2];
                    end
                end
                EXEC: begin
                    r_result     <= ula_saida;
                    r_result_ovf <= ula_flag;
                    if (ula_flag && !w_ovf_sat) r_ovf_count <= r_ovf_count + 1'b1;
                end
                DONE: begin
                    // Accumulate mode: the result becomes the next operand A
                    if (out_ready && r_chain) r_ula_a <= r_result;
                end
                default: begin
                end
            endcase
        end
    end

    assign ula_a      = r_ula_a;
    assign ula_b      = r_ula_b;
    assign ula_f      = r_ula_f;
    assign result     = r_result;
    assign result_ovf = r_result_ovf;
    assign ovf_count  = r_ovf_count;

endmodule

// File: tb/tb_ula_sequencer.sv
// Self-checking bench for ula_sequencer. Hosts a behavioural ALU, drives directed and
// randomized transactions, and compares against a transaction-level reference model.
module tb_ula_sequencer;

    localparam int unsigned CntW   = 4;
    localparam int          CntMax = (1 << CntW) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [7:0]      in_data = 8'h00;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [7:0]      ula_a;
    logic [7:0]      ula_b;
    logic [1:0]      ula_f;
    logic [7:0]      ula_saida;
    logic            ula_flag;
    logic [7:0]      result;
    logic            result_ovf;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [CntW-1:0] ovf_count;

    int checks = 0;
    int failures = 0;

    // Reference model state (transaction level)
    logic [7:0] m_a;
    logic [7:0] m_res;
    logic       m_ovf;
    logic       m_chain;
    int         m_cnt;

    always #5 clk = ~clk;

    ula_sequencer #(.OVF_CNT_W(CntW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ula_a      (ula_a),
        .ula_b      (ula_b),
        .ula_f      (ula_f),
        .ula_saida  (ula_saida),
        .ula_flag   (ula_flag),
        .result     (result),
        .result_ovf (result_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ovf_count  (ovf_count)
    );

    // Signed 8-bit ALU: returns {overflow, result}
    function automatic logic [8:0] alu(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] f);
        int   r;
        logic o;
        o = 1'b0;
        case (f)
            2'd0: r = int'(a & b);
            2'd1: r = int'(a | b);
            2'd2: begin
                r = int'($signed(a)) + int'($signed(b));
                o = (r > 127) || (r < -128);
            end
            default: begin
                r = int'($signed(a)) - int'($signed(b));
                o = (r > 127) || (r < -128);
            end
        endcase
        return {o, r[7:0]};
    endfunction

    always_comb begin
        {ula_flag, ula_saida} = alu(ula_a, ula_b, ula_f);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_a     = 8'h00;
        m_res   = 8'h00;
        m_ovf   = 1'b0;
        m_chain = 1'b0;
        m_cnt   = 0;
    endtask

    // Present one beat; optional idle cycles first. Returns at the negedge after acceptance.
    task automatic send(input logic [7:0] d, input int gap);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        check("in_ready_before_beat", 32'(in_ready), 32'd1);
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset_and_check();
        #2;
        reset = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ula_a", 32'(ula_a), 32'd0);
        check("rst_ula_b", 32'(ula_b), 32'd0);
        check("rst_ula_f", 32'(ula_f), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_result_ovf", 32'(result_ovf), 32'd0);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One full transaction; A beat skipped when the model is in accumulate mode.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input int hold, input int gap);
        logic [8:0] r;
        if (!m_chain) begin
            send(a, gap);
            m_a = a;
        end
        send(b, gap);
        send(op, gap);
        r     = alu(m_a, b, op[1:0]);
        m_res = r[7:0];
        m_ovf = r[8];
        if (m_ovf && m_cnt < CntMax) m_cnt++;
        // Now in EXEC: one edge before out_valid
        check("exec_out_valid", 32'(out_valid), 32'd0);
        check("exec_in_ready", 32'(in_ready), 32'd0);
        check("ula_a", 32'(ula_a), 32'(m_a));
        check("ula_b", 32'(ula_b), 32'(b));
        check("ula_f", 32'(ula_f), 32'(op[1:0]));
        @(negedge clk);
        check("done_out_valid", 32'(out_valid), 32'd1);
        check("done_in_ready", 32'(in_ready), 32'd0);
        check("result", 32'(result), 32'(m_res));
        check("result_ovf", 32'(result_ovf), 32'(m_ovf));
        check("ovf_count", 32'(ovf_count), 32'(m_cnt));
        for (int i = 0; i < hold; i++) begin
            in_data  = 8'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_result", 32'(result), 32'(m_res));
            check("hold_result_ovf", 32'(result_ovf), 32'(m_ovf));
            check("hold_ula_b", 32'(ula_b), 32'(b));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        m_chain   = op[2];
        if (m_chain) m_a = m_res;
        check("after_take_out_valid", 32'(out_valid), 32'd0);
        check("after_take_in_ready", 32'(in_ready), 32'd1);
        check("after_take_ula_a", 32'(ula_a), 32'(m_a));
    endtask

    initial begin
        model_reset();
        #1;
        check("init_in_ready", 32'(in_ready), 32'd1);
        check("init_out_valid", 32'(out_valid), 32'd0);
        check("init_result", 32'(result), 32'd0);
        check("init_ovf_count", 32'(ovf_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Basic add
        run_txn(8'h05, 8'h03, 8'h02, 0, 0);
        check("add_result", 32'(result), 32'h08);
        // Signed overflow on add, then on subtract
        run_txn(8'd100, 8'd100, 8'h02, 0, 0);
        check("ovf1_result", 32'(result), 32'hC8);
        check("ovf1_count", 32'(ovf_count), 32'd1);
        run_txn(8'h80, 8'h01, 8'h03, 0, 1);
        check("ovf2_result", 32'(result), 32'h7F);
        check("ovf2_count", 32'(ovf_count), 32'd2);
        // Accumulate: 10 + 20 = 30, then 30 + 5 = 35
        run_txn(8'd10, 8'd20, 8'h06, 0, 0);
        check("chain1_result", 32'(result), 32'd30);
        check("chain_ula_a_loaded", 32'(ula_a), 32'd30);
        run_txn(8'h00, 8'd5, 8'h02, 0, 0);
        check("chain2_result", 32'(result), 32'd35);
        // Consumer stalls ten cycles while beats are offered
        run_txn(8'hF0, 8'h3C, 8'hF9, 10, 0);
        check("stall_result_or", 32'(result), 32'hFC);

        // Reset mid-load (in LOAD_B after A = 0x7F)
        send(8'h7F, 0);
        pulse_reset_and_check();
        run_txn(8'h0F, 8'h33, 8'h00, 0, 0);
        check("post_rst_result", 32'(result), 32'h03);

        // Reset while in DONE discards the transaction
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h02, 0);
        @(negedge clk);
        check("pre_rst_done", 32'(out_valid), 32'd1);
        pulse_reset_and_check();

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            run_txn(8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
        end

        // Overflow counter saturation
        pulse_reset_and_check();
        for (int t = 0; t < 16; t++) begin
            run_txn(8'd100, 8'd100, 8'h02, 0, 0);
        end
        check("sat_count", 32'(ovf_count), 32'(CntMax));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
